retire_trace_tx: RTL
====================

# retire_trace_tx

Synthesizable retire-trace transmitter at the back of the core, after the ROB retire stage (rb1). It takes one retired-instruction record per cycle (PC, ROB id, GPR write, result data, nuke flag), buffers it in a small FIFO, and serializes it as 32-bit beats on a valid/ready trace port to an off-core collector. The collector rebuilds the same per-instruction retire log that the simulation debug tracker prints.

## Interface
- DEPTH, 4: record FIFO entries; power of two, at least 2.
- ROBID_W, 5: ROB id width; at most 8.
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- trace_en  in  1  capture enable; sampled per cycle.
- retire_valid_rb1  in  1  one instruction retires this cycle.
- retire_pc_rb1  in  32  PC of the retiring instruction.
- retire_robid_rb1  in  ROBID_W  ROB id.
- retire_gpr_we_rb1  in  1  instruction writes a GPR.
- retire_gpr_rb1  in  5  destination GPR.
- retire_data_rb1  in  64  result written.
- retire_nuke_rb1  in  1  retire caused a nuke.
- trace_valid  out  1  beat available.
- trace_data  out  32  beat payload.
- trace_last  out  1  final beat of record.
- trace_ready  in  1  collector accepts beat.
- drop_cnt  out  16  saturating count of dropped records.

## Operation
- Capture:
  - A record is captured when `retire_valid_rb1 & trace_en`.
  - It is written into the FIFO at the clock edge.
  - If `trace_en=0`, retire events are ignored and are not counted as drops.
- Full FIFO:
  - The FIFO is full when count==DEPTH.
  - A capture while full is accepted only if the head record pops in the same cycle.
  - Otherwise the record is dropped: `drop_cnt` increments (saturating at 0xFFFF) and the sticky `drop_pend` flag is set.
- Sequence number and drop flag:
  - `seq[7:0]` increments, mod 256, on each accepted record. Dropped records do not consume a seq value.
  - The next accepted record carries `drop_pend` in its header, and that capture clears `drop_pend`.
  - A drop and an accept cannot occur in the same cycle.
- Beat format:
  - Beat 0 (header):
    - [31:24]=0xA5
    - [23:16]=seq
    - [15]=nuke
    - [14]=gpr_we
    - [13:9]=gpr
    - [8]=drop flag
    - [7:0]=robid, zero-extended
  - Beat 1: PC.
  - Beat 2: data[31:0].
  - Beat 3: data[63:32].
  - A record is 4 beats when gpr_we=1 and 2 beats otherwise.
- Beat sequencer:
  - A 2-bit beat counter selects the payload from the FIFO head entry.
  - `trace_valid` = FIFO non-empty.
  - On a handshake (`trace_valid & trace_ready`):
    - on the last beat, pop the head and reset the counter to 0;
    - otherwise increment the counter.
  - `trace_last` = valid & (beat==1 for a 2-beat record, beat==3 for a 4-beat record).
- Nuke records are transmitted like any other record. The FIFO is never flushed, because its contents are already architecturally retired.
- Changing `trace_en` mid-record never truncates a record already in the FIFO.

## Timing
- Reset (asynchronous, immediate on `reset_n` low):
  - `trace_valid=0`, `trace_data=0`, `trace_last=0`, `drop_cnt=0`.
  - FIFO empty, seq=0, beat=0, `drop_pend=0`.
- Latency: a record captured at edge N drives its header on `trace_valid` from edge N (visible in cycle N+1). Minimum is 1 cycle.
- Throughput: 1 beat per cycle when `trace_ready` is held high. Back-to-back records need no bubble.
- Handshake: once `trace_valid` is high, `trace_data` and `trace_last` stay stable until the handshake. `trace_valid` never drops without a handshake.
- Simultaneous push and pop on an empty FIFO cannot occur: pop requires non-empty.
- Pointers wrap modulo DEPTH; a count register of width $clog2(DEPTH)+1 distinguishes full from empty.
- Reset mid-record: the partial record is lost. The collector resynchronizes on the 0xA5 header.

## Configuration
- `RETIRE_TRACE_DATA_EN` defined:
  - 64-bit data is stored in the FIFO.
  - Records with gpr_we=1 are 4 beats.
- `RETIRE_TRACE_DATA_EN` undefined:
  - Data storage is removed.
  - Every record is 2 beats; header bit 14 still reports gpr_we.
  - `trace_last` asserts at beat 1.

## Test plan
- Single retire, no GPR write:
  - Stimulus: PC=0x1000, robid=3, trace_ready=1.
  - Response: beats 0xA5000003, 0x00001000; last on beat 2; valid low afterwards.
- GPR write (macro on):
  - Stimulus: gpr=5, data=0x0000_0666_DEAD_BEEF, seq=1.
  - Response: header 0xA501_4A03 (robid=3); then PC; 0xDEADBEEF; 0x00000666; last on beat 4.
- Backpressure and overflow:
  - Stimulus: trace_ready=0 with DEPTH=4; retire 6 records in 6 cycles.
  - Response: drop_cnt=2. After releasing ready, 4 records are emitted, seq 0..3; the next accepted record has header bit 8 set and seq=4.
- Full FIFO, retire coinciding with a last-beat pop:
  - Response: record accepted; drop_cnt unchanged.
- Nuke and enable:
  - Stimulus: nuke=1 on a retire.
  - Response: header bit 15 set; queued records still drain.
  - Stimulus: trace_en=0 during a retire.
  - Response: no record; drop_cnt unchanged.
- Reset mid-record:
  - Stimulus: reset_n low after beat 1 of a 4-beat record.
  - Response: trace_valid=0 immediately. After reset, the next record carries seq=0.

Source files
------------

// File: rtl/retire_trace_tx.sv
// Retire-trace transmitter: buffers retired-instruction records and serializes them as 32-bit beats.
// Optional feature macro RETIRE_TRACE_DATA_EN stores 64-bit result data (4-beat GPR-write records).
module retire_trace_tx #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ROBID_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               trace_en,
  input  logic               retire_valid_rb1,
  input  logic [31:0]        retire_pc_rb1,
  input  logic [ROBID_W-1:0] retire_robid_rb1,
  input  logic               retire_gpr_we_rb1,
  input  logic [4:0]         retire_gpr_rb1,
  input  logic [63:0]        retire_data_rb1,
  input  logic               retire_nuke_rb1,
  output logic               trace_valid,
  output logic [31:0]        trace_data,
  output logic               trace_last,
  input  logic               trace_ready,
  output logic [15:0]        drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]         seq_mem   [DEPTH];
  logic [4:0]         gpr_mem   [DEPTH];
  logic [ROBID_W-1:0] robid_mem [DEPTH];
  logic [31:0]        pc_mem    [DEPTH];
  logic [DEPTH-1:0]   nuke_mem, we_mem, drop_mem;
`ifdef RETIRE_TRACE_DATA_EN
  logic [63:0]        data_mem  [DEPTH];
`else
  logic               unused_data;
  assign unused_data = ^retire_data_rb1;
`endif

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]    beat_q, beat_d;
  logic [7:0]    seq_q, seq_d;
  logic          drop_pend_q, drop_pend_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic       capture, full, accept, drop, hs, pop, is_last;
  logic [1:0] last_beat;
  logic [7:0] robid_ext;
  logic [31:0] payload;

  assign trace_valid = (count_q != '0);
  assign full        = (count_q == CW'(DEPTH));
  assign capture     = retire_valid_rb1 & trace_en;

`ifdef RETIRE_TRACE_DATA_EN
  assign last_beat = we_mem[rd_ptr_q] ? 2'd3 : 2'd1;
`else
  assign last_beat = 2'd1;
`endif

  assign is_last    = (beat_q == last_beat);
  assign hs         = trace_valid & trace_ready;
  assign pop        = hs & is_last;
  // A full FIFO still takes a record when the head leaves in the same cycle.
  assign accept     = capture & (~full | pop);
  assign drop       = capture & ~accept;
  assign trace_last = trace_valid & is_last;
  assign drop_cnt   = drop_cnt_q;

  always_comb begin
    robid_ext = '0;
    robid_ext[ROBID_W-1:0] = robid_mem[rd_ptr_q];
  end

  always_comb begin
    payload = '0;
    case (beat_q)
      2'd0: payload = {8'hA5, seq_mem[rd_ptr_q], nuke_mem[rd_ptr_q], we_mem[rd_ptr_q],
                       gpr_mem[rd_ptr_q], drop_mem[rd_ptr_q], robid_ext};
      2'd1: payload = pc_mem[rd_ptr_q];
`ifdef RETIRE_TRACE_DATA_EN
      2'd2: payload = data_mem[rd_ptr_q][31:0];
      2'd3: payload = data_mem[rd_ptr_q][63:32];
`endif
      default: payload = '0;
    endcase
  end

  assign trace_data = trace_valid ? payload : '0;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    beat_d      = beat_q;
    seq_d       = seq_q;
    drop_pend_d = drop_pend_q;
    drop_cnt_d  = drop_cnt_q;
    if (hs) begin
      if (is_last) begin
        beat_d   = '0;
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        beat_d = beat_q + 2'd1;
      end
    end
    if (accept) begin
      wr_ptr_d    = wr_ptr_q + AW'(1);
      seq_d       = seq_q + 8'd1;
      drop_pend_d = 1'b0;
    end else if (drop) begin
      drop_pend_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      beat_q      <= '0;
      seq_q       <= '0;
      drop_pend_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      beat_q      <= beat_d;
      seq_q       <= seq_d;
      drop_pend_q <= drop_pend_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Record storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      seq_mem[wr_ptr_q]   <= seq_q;
      gpr_mem[wr_ptr_q]   <= retire_gpr_rb1;
      robid_mem[wr_ptr_q] <= retire_robid_rb1;
      pc_mem[wr_ptr_q]    <= retire_pc_rb1;
      nuke_mem[wr_ptr_q]  <= retire_nuke_rb1;
      we_mem[wr_ptr_q]    <= retire_gpr_we_rb1;
      drop_mem[wr_ptr_q]  <= drop_pend_q;
`ifdef RETIRE_TRACE_DATA_EN
      data_mem[wr_ptr_q]  <= retire_data_rb1;
`endif
    end
  end

endmodule
